// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - AXI3 single-outstanding burst master for cache-line refill/writeback
// Optional macro AXI_BURST_MASTER_STAT_EN adds read/write/error completion counters.
module axi_burst_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int AXI_ID    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [BURST_LEN*DATA_W-1:0] line_in,
  output logic [BURST_LEN*DATA_W-1:0] line_out,
  output logic                        resp_valid,
  output logic                        resp_err,
  output logic [3:0]                  arid,
  output logic [ADDR_W-1:0]           araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arvalid,
  output logic [1:0]                  arlock,
  output logic [3:0]                  arcache,
  output logic [2:0]                  arprot,
  input  logic                        arready,
  input  logic [3:0]                  rid,
  input  logic [DATA_W-1:0]           rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,
  output logic [3:0]                  awid,
  output logic [ADDR_W-1:0]           awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awvalid,
  output logic [1:0]                  awlock,
  output logic [3:0]                  awcache,
  output logic [2:0]                  awprot,
  input  logic                        awready,
  output logic [3:0]                  wid,
  output logic [DATA_W-1:0]           wdata,
  output logic [DATA_W/8-1:0]         wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [3:0]                  bid,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready
`ifdef AXI_BURST_MASTER_STAT_EN
  ,
  output logic [31:0]                 stat_rd_cnt,
  output logic [31:0]                 stat_wr_cnt,
  output logic [31:0]                 stat_err_cnt
`endif
);

  localparam int LINE_W = BURST_LEN * DATA_W;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int CNT_W  = 9;
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  BEAT_CNT  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

  if (BURST_LEN < 1 || BURST_LEN > 256 || LINE_W / 8 > 4096 ||
      (DATA_W != 32 && DATA_W != 64)) begin : g_bad_cfg
    $error("axi_burst_master: illegal DATA_W/BURST_LEN combination");
  end

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic                err_q;
  logic [CNT_W-1:0]    beat_q;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   line_out_q;
  logic                req_ready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [DATA_W-1:0]   wdata_c;
  logic                rd_err_c;

  // Error state including the beat currently on R: bad response, overflow, or short/long burst at rlast.
  assign rd_err_c = err_q | rresp[1] | (beat_q >= BEAT_CNT) | (rlast & (beat_q != LAST_BEAT));

  always_comb begin
    wdata_c = '0;
    for (int k = 0; k < BURST_LEN; k++) begin
      if (beat_q == CNT_W'(k)) wdata_c = line_q[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      beat_q       <= '0;
      line_q       <= '0;
      line_out_q   <= '0;
      req_ready_q  <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            addr_q      <= req_addr & ADDR_MASK;
            write_q     <= req_write;
            beat_q      <= '0;
            err_q       <= 1'b0;
            if (req_write) begin
              line_q    <= line_in;
              awvalid_q <= 1'b1;
              state_q   <= WADDR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RADDR;
            end
          end
        end
        RADDR: if (arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RDATA;
        end
        RDATA: if (rvalid) begin
          if (beat_q < BEAT_CNT) begin
            for (int k = 0; k < BURST_LEN; k++) begin
              if (beat_q == CNT_W'(k)) line_out_q[k*DATA_W +: DATA_W] <= rdata;
            end
            beat_q <= beat_q + CNT_W'(1);
          end
          err_q <= rd_err_c;
          if (rlast) begin
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= rd_err_c;
            state_q      <= DONE;
          end
        end
        WADDR: if (awready) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          state_q   <= WDATA;
        end
        WDATA: if (wready) begin
          beat_q <= beat_q + CNT_W'(1);
          if (beat_q == LAST_BEAT) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= WRESP;
          end
        end
        WRESP: if (bvalid) begin
          bready_q     <= 1'b0;
          err_q        <= err_q | bresp[1];
          resp_valid_q <= 1'b1;
          resp_err_q   <= err_q | bresp[1];
          state_q      <= DONE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef AXI_BURST_MASTER_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_cnt  <= '0;
      stat_wr_cnt  <= '0;
      stat_err_cnt <= '0;
    end else if (resp_valid_q) begin
      if (write_q) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      else         stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (resp_err_q) stat_err_cnt <= stat_err_cnt + 32'd1;
    end
  end
`endif

  wire unused_inputs = ^{rid, bid, rresp[0], bresp[0]};

  assign req_ready  = req_ready_q;
  assign line_out   = line_out_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;

  assign arid    = 4'(AXI_ID);
  assign araddr  = addr_q;
  assign arlen   = 8'(BURST_LEN - 1);
  assign arsize  = 3'($clog2(DATA_W / 8));
  assign arburst = 2'b01;
  assign arvalid = arvalid_q;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign rready  = rready_q;

  assign awid    = 4'(AXI_ID);
  assign awaddr  = addr_q;
  assign awlen   = 8'(BURST_LEN - 1);
  assign awsize  = 3'($clog2(DATA_W / 8));
  assign awburst = 2'b01;
  assign awvalid = awvalid_q;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wid    = 4'(AXI_ID);
  assign wdata  = wdata_c;
  assign wstrb  = '1;
  assign wlast  = wvalid_q & (beat_q == LAST_BEAT);
  assign wvalid = wvalid_q;
  assign bready = bready_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - randomized self-checking bench for axi_burst_master
// Checks against a line/beat-level model; AXI_BURST_MASTER_STAT_EN enables counter checks.
module tb_axi_burst_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BL = 16;
  localparam int LW = DW * BL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] line_in = '0;
  logic          req_ready, resp_valid, resp_err;
  logic [LW-1:0] line_out;
  logic [3:0]    arid, awid, wid;
  logic [AW-1:0] araddr, awaddr;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize, arprot, awprot;
  logic [1:0]    arburst, awburst, arlock, awlock;
  logic [3:0]    arcache, awcache;
  logic          arvalid, awvalid, rready, wvalid, wlast, bready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          arready = 1'b0, awready = 1'b0, wready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0, bresp = '0;
  logic          rlast = 1'b0, rvalid = 1'b0, bvalid = 1'b0;
`ifdef AXI_BURST_MASTER_STAT_EN
  logic [31:0]   stat_rd_cnt, stat_wr_cnt, stat_err_cnt;
  logic [31:0]   t_stat_rd, t_stat_wr, t_stat_err;
`endif

  // Second instance: 64-bit single-beat configuration
  logic          t_req_valid = 1'b0;
  logic [AW-1:0] t_req_addr = '0;
  logic [63:0]   t_line_in = '0;
  logic          t_req_ready, t_resp_valid, t_resp_err;
  logic [63:0]   t_line_out, t_wdata;
  logic [3:0]    t_arid, t_awid, t_wid;
  logic [AW-1:0] t_araddr, t_awaddr;
  logic [7:0]    t_arlen, t_awlen;
  logic [2:0]    t_arsize, t_awsize, t_arprot, t_awprot;
  logic [1:0]    t_arburst, t_awburst, t_arlock, t_awlock;
  logic [3:0]    t_arcache, t_awcache;
  logic          t_arvalid, t_awvalid, t_rready, t_wvalid, t_wlast, t_bready;
  logic [7:0]    t_wstrb;
  logic          t_awready = 1'b0, t_wready = 1'b0, t_bvalid = 1'b0;

  axi_burst_master u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .line_in(line_in), .line_out(line_out), .resp_valid(resp_valid),
    .resp_err(resp_err), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arready(arready), .rid(4'd0), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(4'd0), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef AXI_BURST_MASTER_STAT_EN
    , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_err_cnt(stat_err_cnt)
`endif
  );

  axi_burst_master #(.DATA_W(64), .BURST_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_ready(t_req_ready), .req_write(1'b1),
    .req_addr(t_req_addr), .line_in(t_line_in), .line_out(t_line_out), .resp_valid(t_resp_valid),
    .resp_err(t_resp_err), .arid(t_arid), .araddr(t_araddr), .arlen(t_arlen), .arsize(t_arsize),
    .arburst(t_arburst), .arvalid(t_arvalid), .arlock(t_arlock), .arcache(t_arcache),
    .arprot(t_arprot), .arready(1'b0), .rid(4'd0), .rdata(64'd0), .rresp(2'b00), .rlast(1'b0),
    .rvalid(1'b0), .rready(t_rready), .awid(t_awid), .awaddr(t_awaddr), .awlen(t_awlen),
    .awsize(t_awsize), .awburst(t_awburst), .awvalid(t_awvalid), .awlock(t_awlock),
    .awcache(t_awcache), .awprot(t_awprot), .awready(t_awready), .wid(t_wid), .wdata(t_wdata),
    .wstrb(t_wstrb), .wlast(t_wlast), .wvalid(t_wvalid), .wready(t_wready), .bid(4'd0),
    .bresp(2'b00), .bvalid(t_bvalid), .bready(t_bready)
`ifdef AXI_BURST_MASTER_STAT_EN
    , .stat_rd_cnt(t_stat_rd), .stat_wr_cnt(t_stat_wr), .stat_err_cnt(t_stat_err)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] m_line [BL];
  int m_rd = 0, m_wr = 0, m_err = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [LW-1:0] model_line();
    logic [LW-1:0] v;
    for (int k = 0; k < BL; k++) v[k*DW +: DW] = m_line[k];
    return v;
  endfunction

  task automatic request(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l,
                         input bit hold, output int waits);
    req_valid = 1'b1; req_write = wr; req_addr = a; line_in = l; waits = 0;
    while (req_ready !== 1'b1 && waits < 50) begin step(); waits++; end
    chk("req_accept_timeout", LW'(waits < 50), LW'(1));
    step();
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int nbeats, input int errbeat,
                         input bit hold, input bit seq);
    int waits;
    bit exp_err;
    request(1'b0, a, '0, hold, waits);
    chk("arvalid_after_accept", LW'(arvalid), LW'(1));
    chk("req_ready_busy", LW'(req_ready), LW'(0));
    repeat ($urandom_range(0, 3)) begin
      chk("araddr_hold", LW'({arvalid, araddr}), LW'({1'b1, a & ~32'h3F}));
      step();
    end
    chk("araddr", LW'(araddr), LW'(a & ~32'h3F));
    arready = 1'b1; step(); arready = 1'b0;
    chk("arvalid_drop", LW'(arvalid), LW'(0));
    exp_err = (nbeats != BL);
    for (int k = 0; k < nbeats; k++) begin
      repeat ($urandom_range(0, 2)) begin rvalid = 1'b0; step(); end
      chk("rready", LW'(rready), LW'(1));
      rvalid = 1'b1;
      rdata  = seq ? DW'(k) : DW'($urandom);
      rresp  = (k == errbeat) ? 2'b10 : {1'b0, 1'($urandom_range(0, 1))};
      rlast  = (k == nbeats - 1);
      if (k < BL) m_line[k] = rdata;
      if (k == errbeat) exp_err = 1'b1;
      step();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    chk("rd_resp_valid", LW'(resp_valid), LW'(1));
    chk("rd_resp_err", LW'(resp_err), LW'(exp_err));
    m_rd++;
    if (exp_err) m_err++;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] l, input bit toggle,
                          input int bdly, input bit berr, output int waits);
    int  k, cyc;
    bit  ph;
    request(1'b1, a, l, 1'b0, waits);
    chk("awvalid_after_accept", LW'(awvalid), LW'(1));
    chk("awaddr", LW'(awaddr), LW'(a & ~32'h3F));
    repeat ($urandom_range(0, 3)) begin
      chk("w_before_aw", LW'(wvalid), LW'(0));
      step();
    end
    chk("w_before_aw", LW'(wvalid), LW'(0));
    awready = 1'b1; step(); awready = 1'b0;
    chk("awvalid_drop", LW'(awvalid), LW'(0));
    k = 0; cyc = 0; ph = 1'b0;
    while (k < BL && cyc < 200) begin
      chk("wvalid", LW'(wvalid), LW'(1));
      chk("wdata", LW'(wdata), LW'(l[k*DW +: DW]));
      chk("wlast", LW'(wlast), LW'(k == BL - 1));
      wready = toggle ? ph : 1'($urandom_range(0, 1));
      ph = ~ph;
      step();
      if (wready) k++;
      cyc++;
    end
    wready = 1'b0;
    chk("w_beats", LW'(k), LW'(BL));
    chk("wvalid_after_last", LW'(wvalid), LW'(0));
    chk("bready", LW'(bready), LW'(1));
    repeat (bdly) begin
      step();
      chk("no_resp_before_b", LW'(resp_valid), LW'(0));
    end
    bvalid = 1'b1; bresp = berr ? 2'b10 : 2'b00;
    step();
    bvalid = 1'b0; bresp = 2'b00;
    chk("wr_resp_valid", LW'(resp_valid), LW'(1));
    chk("wr_resp_err", LW'(resp_err), LW'(berr));
    m_wr++;
    if (berr) m_err++;
  endtask

  task automatic idle_check();
    step();
    chk("resp_single_pulse", LW'(resp_valid), LW'(0));
    chk("idle_req_ready", LW'(req_ready), LW'(1));
    chk("line_out", line_out, model_line());
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < BL; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  initial begin
    int waits;
    logic [LW-1:0] l;
    for (int k = 0; k < BL; k++) m_line[k] = '0;

    #1;
    chk("reset_outputs", LW'({req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid}), LW'(0));
    chk("reset_line_out", line_out, LW'(0));
    step(); rst = 1'b0; step();
    chk("req_ready_after_reset", LW'(req_ready), LW'(1));
    chk("ar_consts", LW'({arid, arlen, arsize, arburst}), LW'({4'd0, 8'd15, 3'd2, 2'b01}));
    chk("aw_consts", LW'({awid, awlen, awsize, awburst, wstrb}), LW'({4'd0, 8'd15, 3'd2, 2'b01, 4'hF}));

    // 64-bit single-beat write
    chk("t_aw_consts", LW'({t_awlen, t_awsize, t_awburst, t_wstrb}), LW'({8'd0, 3'd3, 2'b01, 8'hFF}));
    t_req_valid = 1'b1; t_req_addr = 32'h2000_000C; t_line_in = 64'hDEAD_BEEF_0123_4567;
    step(); t_req_valid = 1'b0;
    chk("t_awvalid", LW'({t_awvalid, t_wvalid}), LW'(2'b10));
    chk("t_awaddr", LW'(t_awaddr), LW'(32'h2000_0008));
    t_awready = 1'b1; step(); t_awready = 1'b0;
    chk("t_wbeat", LW'({t_wvalid, t_wlast, t_wdata}), LW'({2'b11, 64'hDEAD_BEEF_0123_4567}));
    t_wready = 1'b1; step(); t_wready = 1'b0;
    chk("t_bready", LW'({t_wvalid, t_bready}), LW'(2'b01));
    t_bvalid = 1'b1; step(); t_bvalid = 1'b0;
    chk("t_resp", LW'({t_resp_valid, t_resp_err}), LW'(2'b10));
    step();
    chk("t_idle", LW'({t_resp_valid, t_req_ready}), LW'(2'b01));

    do_read(32'h1000_0004, 16, -1, 1'b0, 1'b1);
    idle_check();

    for (int k = 0; k < BL; k++) l[k*DW +: DW] = 32'hA5A5_0000 + DW'(k);
    do_write(32'h1000_0040, l, 1'b1, 5, 1'b0, waits);
    idle_check();

    do_read(32'h0000_1234, 16, 3, 1'b0, 1'b0);
    idle_check();
    do_read(32'h0000_5678, 10, -1, 1'b0, 1'b0);
    idle_check();
    do_read(32'hABCD_0000, 18, -1, 1'b0, 1'b0);
    idle_check();

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write($urandom, rand_line(), 1'b0, $urandom_range(0, 4),
                 ($urandom_range(0, 3) == 0), waits);
      end else begin
        case ($urandom_range(0, 5))
          0:       do_read($urandom, 15, -1, 1'b0, 1'b0);
          1:       do_read($urandom, 17, -1, 1'b0, 1'b0);
          default: do_read($urandom, 16, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1,
                           1'b0, 1'b0);
        endcase
      end
      idle_check();
    end

    do_read(32'h3000_0000, 16, -1, 1'b1, 1'b0);
    do_write(32'h3000_0040, rand_line(), 1'b0, 1, 1'b0, waits);
    chk("b2b_accept_wait", LW'(waits), LW'(1));
    idle_check();

`ifdef AXI_BURST_MASTER_STAT_EN
    chk("stat_rd", LW'(stat_rd_cnt), LW'(m_rd));
    chk("stat_wr", LW'(stat_wr_cnt), LW'(m_wr));
    chk("stat_err", LW'(stat_err_cnt), LW'(m_err));
    chk("t_stat", LW'({t_stat_rd, t_stat_wr, t_stat_err}), LW'({32'd0, 32'd1, 32'd0}));
`endif

    // Reset in the middle of a read burst
    request(1'b0, 32'h4000_0000, '0, 1'b0, waits);
    arready = 1'b1; step(); arready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      rvalid = 1'b1; rdata = DW'($urandom); step();
    end
    rvalid = 1'b1; rdata = DW'($urandom);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ctrl", LW'({req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err}), LW'(0));
    chk("rst_async_line", line_out, LW'(0));
    rvalid = 1'b0;
    step(); rst = 1'b0;
    for (int k = 0; k < BL; k++) m_line[k] = '0;
    step();
    chk("rst_req_ready", LW'(req_ready), LW'(1));
    repeat (3) begin
      step();
      chk("rst_no_resp", LW'({resp_valid, rready}), LW'(0));
    end
`ifdef AXI_BURST_MASTER_STAT_EN
    chk("stat_cleared", LW'({stat_rd_cnt, stat_wr_cnt, stat_err_cnt}), LW'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
